// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared definitions for the memory-access stage.
// Purpose: FSM state encoding, bit positions of the one-hot
// load/store info vector, and the base byte-strobe patterns that
// get shifted into position by the byte offset.
// Ports: none (package).
package lsu_pkg;

  // Stage sequencing: idle, request issued, waiting for load data,
  // result presented to writeback.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_OUT  = 2'd3
  } lsu_state_e;

  // Bit positions inside load_store_info (one-hot, all-zero = ALU op).
  localparam int LS_LB  = 7;
  localparam int LS_LH  = 6;
  localparam int LS_LW  = 5;
  localparam int LS_LBU = 4;
  localparam int LS_LHU = 3;
  localparam int LS_SB  = 2;
  localparam int LS_SH  = 1;
  localparam int LS_SW  = 0;

  // Strobe patterns for lane 0; byte/half are shifted by the offset.
  localparam logic [3:0] STRB_BYTE = 4'b0001;
  localparam logic [3:0] STRB_HALF = 4'b0011;
  localparam logic [3:0] STRB_WORD = 4'b1111;

endpackage

// File: rtl/lsu_mem_stage_align.sv
// lsu_align -- combinational lane logic for the memory-access stage.
// Purpose: decodes the load/store info vector (lowest set bit wins),
// builds store strobes and lane-replicated store data from the live
// execute inputs, and extracts/extends load data using the access
// parameters captured when the load was accepted.
// Ports:
//   info_i, off_i, store_data_i   live execute-side decode inputs
//   ld_sel_o, is_load_o, is_store_o  decoded access class
//   wstrb_o, wdata_o              store strobes and replicated data
//   misalign_o                    misaligned access (LSU_MISALIGN_TRAP_EN only)
//   ld_sel_i, ld_off_i, rdata_i   captured load kind/offset and memory word
//   ld_data_o                     extended load result
// Configuration: `define LSU_MISALIGN_TRAP_EN adds misalign_o.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [7:0]          info_i,
  input  logic [1:0]          off_i,
  input  logic [31:0]         store_data_i,
  output logic [LS_LB:LS_LHU] ld_sel_o,
  output logic                is_load_o,
  output logic                is_store_o,
  output logic [3:0]          wstrb_o,
  output logic [31:0]         wdata_o,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic                misalign_o,
`endif
  input  logic [LS_LB:LS_LHU] ld_sel_i,
  input  logic [1:0]          ld_off_i,
  input  logic [31:0]         rdata_i,
  output logic [31:0]         ld_data_o
);

  logic [7:0]  sel;
  logic [31:0] word;

  // Isolate the lowest set bit so a malformed multi-hot vector still
  // selects exactly one access type.
  assign sel        = info_i & (~info_i + 8'd1);
  assign ld_sel_o   = sel[LS_LB:LS_LHU];
  assign is_load_o  = |sel[LS_LB:LS_LHU];
  assign is_store_o = |sel[LS_SB:LS_SW];

  // Strobes shifted past lane 3 fall off the 4-bit result.
  always_comb begin
    wstrb_o = 4'b0000;
    wdata_o = 32'h0;
    if (sel[LS_SB]) begin
      wstrb_o = STRB_BYTE << off_i;
      wdata_o = {4{store_data_i[7:0]}};
    end else if (sel[LS_SH]) begin
      wstrb_o = STRB_HALF << off_i;
      wdata_o = {2{store_data_i[15:0]}};
    end else if (sel[LS_SW]) begin
      wstrb_o = STRB_WORD;
      wdata_o = store_data_i;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_o = ((sel[LS_LH] | sel[LS_LHU] | sel[LS_SH]) & off_i[0]) |
                      ((sel[LS_LW] | sel[LS_SW]) & (off_i != 2'b00));
`endif

  // The shift zero-fills, so bytes beyond lane 3 read as zero.
  assign word = rdata_i >> {ld_off_i, 3'b000};

  always_comb begin
    ld_data_o = 32'h0;
    if (ld_sel_i[LS_LB])       ld_data_o = {{24{word[7]}}, word[7:0]};
    else if (ld_sel_i[LS_LBU]) ld_data_o = {24'h0, word[7:0]};
    else if (ld_sel_i[LS_LH])  ld_data_o = {{16{word[15]}}, word[15:0]};
    else if (ld_sel_i[LS_LHU]) ld_data_o = {16'h0, word[15:0]};
    else if (ld_sel_i[LS_LW])  ld_data_o = word;
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage -- memory-access stage between execute and writeback.
// Purpose: issues data-memory loads/stores over req/gnt/rvalid and
// hands a registered result to writeback over valid/ready. ALU ops
// pass through with one cycle of latency.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ex_*/rd_*/pc_i, *_i      execute results; ex_ready_o accept handshake
//   dmem_*                   data-memory request/response interface
//   wb_*                     registered writeback result, valid/ready
//   misalign_o               misaligned-access flag (LSU_MISALIGN_TRAP_EN only)
// Configuration: `define LSU_MISALIGN_TRAP_EN to turn misaligned
// accesses into a flagged, memory-free writeback of the address.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int REG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid_i,
  output logic                 ex_ready_o,
  input  logic [7:0]           load_store_info_i,
  input  logic [WIDTH-1:0]     alu_result_i,
  input  logic [WIDTH-1:0]     mem_addr_i,
  input  logic [WIDTH-1:0]     store_data_i,
  input  logic [REG_WIDTH-1:0] rd_i,
  input  logic                 rd_wen_i,
  input  logic [WIDTH-1:0]     pc_i,
  output logic                 dmem_req_o,
  output logic                 dmem_we_o,
  output logic [WIDTH-1:0]     dmem_addr_o,
  output logic [3:0]           dmem_wstrb_o,
  output logic [WIDTH-1:0]     dmem_wdata_o,
  input  logic                 dmem_gnt_i,
  input  logic                 dmem_rvalid_i,
  input  logic [WIDTH-1:0]     dmem_rdata_i,
  output logic                 wb_valid_o,
  input  logic                 wb_ready_i,
  output logic [REG_WIDTH-1:0] wb_rd_o,
  output logic                 wb_wen_o,
  output logic [WIDTH-1:0]     wb_data_o,
  output logic [WIDTH-1:0]     wb_pc_o
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic                 misalign_o
`endif
);

  lsu_state_e           state_q, state_d;
  logic                 req_q, req_d;
  logic                 we_q, we_d;
  logic [WIDTH-1:0]     addr_q, addr_d;
  logic [3:0]           wstrb_q, wstrb_d;
  logic [WIDTH-1:0]     wdata_q, wdata_d;
  logic [LS_LB:LS_LHU]  ld_sel_q, ld_sel_d;
  logic [1:0]           off_q, off_d;
  logic                 valid_q, valid_d;
  logic [REG_WIDTH-1:0] rd_q, rd_d;
  logic                 wen_q, wen_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [WIDTH-1:0]     pc_q, pc_d;
`ifdef LSU_MISALIGN_TRAP_EN
  logic                 mis_q, mis_d;
  logic                 a_misalign;
`endif

  logic                 accept;
  logic [LS_LB:LS_LHU]  a_ld_sel;
  logic                 a_is_load, a_is_store;
  logic [3:0]           a_wstrb;
  logic [WIDTH-1:0]     a_wdata;
  logic [WIDTH-1:0]     a_ld_data;

  // Strobes/data come from the live inputs; extraction uses the load
  // kind and offset captured at accept time.
  lsu_align u_align (
    .info_i       (load_store_info_i),
    .off_i        (mem_addr_i[1:0]),
    .store_data_i (store_data_i),
    .ld_sel_o     (a_ld_sel),
    .is_load_o    (a_is_load),
    .is_store_o   (a_is_store),
    .wstrb_o      (a_wstrb),
    .wdata_o      (a_wdata),
`ifdef LSU_MISALIGN_TRAP_EN
    .misalign_o   (a_misalign),
`endif
    .ld_sel_i     (ld_sel_q),
    .ld_off_i     (off_q),
    .rdata_i      (dmem_rdata_i),
    .ld_data_o    (a_ld_data)
  );

  // Accepting while OUT is being drained keeps ALU ops at full rate.
  assign ex_ready_o = (state_q == S_IDLE) | ((state_q == S_OUT) & wb_ready_i);
  assign accept     = ex_valid_i & ex_ready_o;

  // Next-state and next-output computation for the whole stage.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wstrb_d  = wstrb_q;
    wdata_d  = wdata_q;
    ld_sel_d = ld_sel_q;
    off_d    = off_q;
    valid_d  = valid_q;
    rd_d     = rd_q;
    wen_d    = wen_q;
    data_d   = data_q;
    pc_d     = pc_q;
`ifdef LSU_MISALIGN_TRAP_EN
    mis_d    = mis_q;
`endif
    case (state_q)
      S_IDLE, S_OUT: begin
        if ((state_q == S_OUT) && wb_ready_i) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
          mis_d   = 1'b0;
`endif
        end
        if (accept) begin
          rd_d     = rd_i;
          pc_d     = pc_i;
          off_d    = mem_addr_i[1:0];
          ld_sel_d = a_ld_sel;
          if (!a_is_load && !a_is_store) begin
            state_d = S_OUT;
            valid_d = 1'b1;
            wen_d   = rd_wen_i;
            data_d  = alu_result_i;
          end
`ifdef LSU_MISALIGN_TRAP_EN
          else if (a_misalign) begin
            state_d = S_OUT;
            valid_d = 1'b1;
            wen_d   = 1'b0;
            data_d  = mem_addr_i;
            mis_d   = 1'b1;
          end
`endif
          else begin
            state_d = S_REQ;
            valid_d = 1'b0;
            req_d   = 1'b1;
            we_d    = a_is_store;
            addr_d  = {mem_addr_i[WIDTH-1:2], 2'b00};
            wstrb_d = a_wstrb;
            wdata_d = a_wdata;
            wen_d   = a_is_load & rd_wen_i;
          end
        end
      end
      S_REQ: begin
        if (dmem_gnt_i) begin
          req_d = 1'b0;
          if (we_q) begin
            state_d = S_OUT;
            valid_d = 1'b1;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (dmem_rvalid_i) begin
          state_d = S_OUT;
          valid_d = 1'b1;
          data_d  = a_ld_data;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset abandons any in-flight access and clears every output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wstrb_q  <= 4'b0000;
      wdata_q  <= '0;
      ld_sel_q <= '0;
      off_q    <= 2'b00;
      valid_q  <= 1'b0;
      rd_q     <= '0;
      wen_q    <= 1'b0;
      data_q   <= '0;
      pc_q     <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wstrb_q  <= wstrb_d;
      wdata_q  <= wdata_d;
      ld_sel_q <= ld_sel_d;
      off_q    <= off_d;
      valid_q  <= valid_d;
      rd_q     <= rd_d;
      wen_q    <= wen_d;
      data_q   <= data_d;
      pc_q     <= pc_d;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q    <= mis_d;
`endif
    end
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wstrb_o = wstrb_q;
  assign dmem_wdata_o = wdata_q;
  assign wb_valid_o   = valid_q;
  assign wb_rd_o      = rd_q;
  assign wb_wen_o     = wen_q;
  assign wb_data_o    = data_q;
  assign wb_pc_o      = pc_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_o   = mis_q;
`endif

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage -- self-checking bench for lsu_mem_stage.
// Expected writeback transactions are queued when an instruction is
// issued and compared when the stage hands them to writeback. A small
// memory responder models grant delay and one-cycle load response.
// Honours LSU_MISALIGN_TRAP_EN the same way as the design.
module tb_lsu_mem_stage;

  localparam logic [7:0] I_LB  = 8'h80;
  localparam logic [7:0] I_LH  = 8'h40;
  localparam logic [7:0] I_LW  = 8'h20;
  localparam logic [7:0] I_LBU = 8'h10;
  localparam logic [7:0] I_LHU = 8'h08;
  localparam logic [7:0] I_SB  = 8'h04;
  localparam logic [7:0] I_SH  = 8'h02;
  localparam logic [7:0] I_SW  = 8'h01;

  logic        clk, rst;
  logic        ex_valid_i, ex_ready_o;
  logic [7:0]  load_store_info_i;
  logic [31:0] alu_result_i, mem_addr_i, store_data_i, pc_i;
  logic [4:0]  rd_i;
  logic        rd_wen_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_wstrb_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o, wb_ready_i, wb_wen_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o, wb_pc_o;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  lsu_mem_stage #(.WIDTH(32), .REG_WIDTH(5)) dut (
    .clk               (clk),
    .rst               (rst),
    .ex_valid_i        (ex_valid_i),
    .ex_ready_o        (ex_ready_o),
    .load_store_info_i (load_store_info_i),
    .alu_result_i      (alu_result_i),
    .mem_addr_i        (mem_addr_i),
    .store_data_i      (store_data_i),
    .rd_i              (rd_i),
    .rd_wen_i          (rd_wen_i),
    .pc_i              (pc_i),
    .dmem_req_o        (dmem_req_o),
    .dmem_we_o         (dmem_we_o),
    .dmem_addr_o       (dmem_addr_o),
    .dmem_wstrb_o      (dmem_wstrb_o),
    .dmem_wdata_o      (dmem_wdata_o),
    .dmem_gnt_i        (dmem_gnt_i),
    .dmem_rvalid_i     (dmem_rvalid_i),
    .dmem_rdata_i      (dmem_rdata_i),
    .wb_valid_o        (wb_valid_o),
    .wb_ready_i        (wb_ready_i),
    .wb_rd_o           (wb_rd_o),
    .wb_wen_o          (wb_wen_o),
    .wb_data_o         (wb_data_o),
    .wb_pc_o           (wb_pc_o)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .misalign_o        (misalign_o)
`endif
  );

  typedef struct {
    logic [31:0] data;
    logic        chk_data;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] pc;
    logic        mis;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  int          gnt_delay   = 0;
  logic [31:0] mem_rdata   = 32'h0;
  logic        hold_rvalid = 1'b0;
  logic        pend        = 1'b0;
  int          req_cnt     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: grants after gnt_delay extra request cycles and
  // returns load data the cycle after the grant.
  always @(posedge clk) begin
    #1;
    if (pend && !hold_rvalid) begin
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = mem_rdata;
      pend          = 1'b0;
    end else begin
      dmem_rvalid_i = 1'b0;
      dmem_rdata_i  = 32'h0;
    end
    if (dmem_req_o && !dmem_gnt_i) begin
      req_cnt++;
      if (req_cnt > gnt_delay) begin
        dmem_gnt_i = 1'b1;
        pend       = !dmem_we_o;
        req_cnt    = 0;
      end
    end else begin
      dmem_gnt_i = 1'b0;
      req_cnt    = 0;
    end
  end

  // Scoreboard: compare each writeback handshake against the queue.
  exp_t e;
  always @(negedge clk) begin
    if (!rst && wb_valid_o && wb_ready_i) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_unexpected wb_data=%h wb_rd=%0d required none", wb_data_o, wb_rd_o);
      end else begin
        e = sb_q.pop_front();
        if (e.chk_data) begin
          checks++;
          if (wb_data_o !== e.data) begin
            errors++;
            $display("[TB] FAIL sb_data got %h expected %h", wb_data_o, e.data);
          end
        end
        checks++;
        if (wb_rd_o !== e.rd) begin
          errors++;
          $display("[TB] FAIL sb_rd got %0d expected %0d", wb_rd_o, e.rd);
        end
        checks++;
        if (wb_wen_o !== e.wen) begin
          errors++;
          $display("[TB] FAIL sb_wen got %b expected %b", wb_wen_o, e.wen);
        end
        checks++;
        if (wb_pc_o !== e.pc) begin
          errors++;
          $display("[TB] FAIL sb_pc got %h expected %h", wb_pc_o, e.pc);
        end
`ifdef LSU_MISALIGN_TRAP_EN
        checks++;
        if (misalign_o !== e.mis) begin
          errors++;
          $display("[TB] FAIL sb_misalign got %b expected %b", misalign_o, e.mis);
        end
`endif
      end
    end
  end

  task automatic push_exp(input logic [31:0] data, input logic chk, input logic [4:0] rd,
                          input logic wen, input logic [31:0] pc, input logic mis);
    exp_t x;
    x.data = data; x.chk_data = chk; x.rd = rd; x.wen = wen; x.pc = pc; x.mis = mis;
    sb_q.push_back(x);
  endtask

  // Drives one execute result and returns after the accepting edge
  // (+1 time unit); waits counts cycles spent stalled.
  task automatic issue(input logic [7:0] info, input logic [31:0] alu, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [4:0] rd, input logic wen,
                       input logic [31:0] pc, output int waits);
    logic accepted;
    ex_valid_i = 1'b1; load_store_info_i = info; alu_result_i = alu; mem_addr_i = addr;
    store_data_i = sdata; rd_i = rd; rd_wen_i = wen; pc_i = pc;
    waits = 0;
    forever begin
      @(negedge clk);
      accepted = ex_ready_o;
      @(posedge clk); #1;
      if (accepted) break;
      waits++;
      if (waits > 50) begin
        checks++; errors++;
        $display("[TB] FAIL issue_timeout ex_ready=%b required 1", ex_ready_o);
        break;
      end
    end
    ex_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++; errors++;
      $display("[TB] FAIL drain_timeout pending=%0d required 0", sb_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ex_valid_i = 1'b0; wb_ready_i = 1'b1;
    load_store_info_i = 8'h0; alu_result_i = 32'h0; mem_addr_i = 32'h0; store_data_i = 32'h0;
    rd_i = 5'd0; rd_wen_i = 1'b0; pc_i = 32'h0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (ex_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_ex_ready got %b expected 1", ex_ready_o); end
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_wb_valid got %b expected 0", wb_valid_o); end
    checks++; if (dmem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_req got %b expected 0", dmem_req_o); end
    checks++; if (wb_data_o !== 32'h0) begin errors++; $display("[TB] FAIL rst_wb_data got %h expected 0", wb_data_o); end
    checks++; if (dmem_wstrb_o !== 4'h0) begin errors++; $display("[TB] FAIL rst_wstrb got %b expected 0", dmem_wstrb_o); end
    checks++; if (dmem_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL rst_addr got %h expected 0", dmem_addr_o); end
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (misalign_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_misalign got %b expected 0", misalign_o); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    int w, t0;
    wb_ready_i = 1'b1;
    push_exp(32'h1234_5678, 1'b1, 5'd5, 1'b1, 32'h100, 1'b0);
    issue(8'h00, 32'h1234_5678, 32'hDEAD_0000, 32'h0, 5'd5, 1'b1, 32'h100, w);
    @(negedge clk);
    checks++; if (wb_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL alu_latency wb_valid got %b expected 1", wb_valid_o); end
    checks++; if (wb_data_o !== 32'h1234_5678) begin errors++; $display("[TB] FAIL alu_data got %h expected 12345678", wb_data_o); end
    @(posedge clk); #1;
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      push_exp(32'h1111_1111 * (i + 1), 1'b1, 5'(i + 1), i[0], 32'h104 + 4 * i, 1'b0);
      issue(8'h00, 32'h1111_1111 * (i + 1), 32'h0, 32'h0, 5'(i + 1), i[0], 32'h104 + 4 * i, w);
    end
    checks++; if (cyc - t0 !== 4) begin errors++; $display("[TB] FAIL alu_full_rate cycles got %0d expected 4", cyc - t0); end
    wait_drain();
  endtask

  task automatic test_store();
    int w, req_cycles;
    gnt_delay = 3;
    push_exp(32'h0, 1'b0, 5'd7, 1'b0, 32'h200, 1'b0);
    issue(I_SB, 32'h0, 32'h1003, 32'hAABB_CCDD, 5'd7, 1'b1, 32'h200, w);
    req_cycles = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dmem_req_o) begin
        req_cycles++;
        checks++; if (dmem_addr_o !== 32'h1000) begin errors++; $display("[TB] FAIL sb_addr got %h expected 00001000", dmem_addr_o); end
        checks++; if (dmem_wstrb_o !== 4'b1000) begin errors++; $display("[TB] FAIL sb_wstrb got %b expected 1000", dmem_wstrb_o); end
        checks++; if (dmem_wdata_o !== 32'hDDDD_DDDD) begin errors++; $display("[TB] FAIL sb_wdata got %h expected dddddddd", dmem_wdata_o); end
        checks++; if (dmem_we_o !== 1'b1) begin errors++; $display("[TB] FAIL sb_we got %b expected 1", dmem_we_o); end
      end else if (req_cycles > 0) begin
        break;
      end
    end
    @(posedge clk); #1;
    checks++; if (req_cycles !== 4) begin errors++; $display("[TB] FAIL sb_req_hold cycles got %0d expected 4", req_cycles); end
    wait_drain();

    gnt_delay = 0;
    push_exp(32'h0, 1'b0, 5'd8, 1'b0, 32'h204, 1'b0);
    issue(I_SW, 32'h0, 32'h1004, 32'h1122_3344, 5'd8, 1'b1, 32'h204, w);
    @(negedge clk);
    checks++; if (dmem_wstrb_o !== 4'b1111) begin errors++; $display("[TB] FAIL sw_wstrb got %b expected 1111", dmem_wstrb_o); end
    checks++; if (dmem_wdata_o !== 32'h1122_3344) begin errors++; $display("[TB] FAIL sw_wdata got %h expected 11223344", dmem_wdata_o); end
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL sw_early_valid got %b expected 0", wb_valid_o); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (wb_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL sw_latency wb_valid got %b expected 1", wb_valid_o); end
    @(posedge clk); #1;
    wait_drain();

    push_exp(32'h0, 1'b0, 5'd9, 1'b0, 32'h208, 1'b0);
    issue(I_SH, 32'h0, 32'h1002, 32'h1234_BEEF, 5'd9, 1'b1, 32'h208, w);
    @(negedge clk);
    checks++; if (dmem_wstrb_o !== 4'b1100) begin errors++; $display("[TB] FAIL sh_wstrb got %b expected 1100", dmem_wstrb_o); end
    checks++; if (dmem_wdata_o !== 32'hBEEF_BEEF) begin errors++; $display("[TB] FAIL sh_wdata got %h expected beefbeef", dmem_wdata_o); end
    @(posedge clk); #1;
    wait_drain();

    // lb and sw both set: sw (lowest bit) must win, so a store with wen=0.
    push_exp(32'h0, 1'b0, 5'd10, 1'b0, 32'h20C, 1'b0);
    issue(8'h81, 32'h0, 32'h1008, 32'h5566_7788, 5'd10, 1'b1, 32'h20C, w);
    @(negedge clk);
    checks++; if (dmem_we_o !== 1'b1) begin errors++; $display("[TB] FAIL prio_we got %b expected 1", dmem_we_o); end
    checks++; if (dmem_wstrb_o !== 4'b1111) begin errors++; $display("[TB] FAIL prio_wstrb got %b expected 1111", dmem_wstrb_o); end
    @(posedge clk); #1;
    wait_drain();
  endtask

  task automatic test_loads();
    logic [7:0]  info_t [6] = '{I_LB, I_LBU, I_LHU, I_LH, I_LW, I_LB};
    logic [31:0] addr_t [6] = '{32'h2002, 32'h2002, 32'h2002, 32'h2002, 32'h2000, 32'h2003};
    logic [31:0] rdat_t [6] = '{32'h0080_0000, 32'h0080_0000, 32'h8001_0000, 32'h8001_0000,
                                32'hDEAD_BEEF, 32'h7F12_3456};
    logic [31:0] exp_t6 [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_8001, 32'hFFFF_8001,
                                32'hDEAD_BEEF, 32'h0000_007F};
    logic [2:0] seen;
    int w;
    gnt_delay = 0;
    for (int i = 0; i < 6; i++) begin
      mem_rdata = rdat_t[i];
      push_exp(exp_t6[i], 1'b1, 5'(12 + i), 1'b1, 32'h400 + 4 * i, 1'b0);
      issue(info_t[i], 32'h0BAD, addr_t[i], 32'hFFFF_FFFF, 5'(12 + i), 1'b1, 32'h400 + 4 * i, w);
      if (i == 0) begin
        seen = 3'b000;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          seen[k] = wb_valid_o;
          if (k == 0) begin
            checks++; if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b0) begin
              errors++; $display("[TB] FAIL lb_req req=%b we=%b expected req=1 we=0", dmem_req_o, dmem_we_o);
            end
          end
          @(posedge clk); #1;
        end
        checks++; if (seen !== 3'b100) begin errors++; $display("[TB] FAIL load_latency valid_trace got %b expected 100", seen); end
      end
      wait_drain();
    end
  endtask

  task automatic test_backpressure();
    int w;
    wb_ready_i = 1'b0;
    push_exp(32'hCAFE_F00D, 1'b1, 5'd3, 1'b1, 32'h300, 1'b0);
    issue(8'h00, 32'hCAFE_F00D, 32'h0, 32'h0, 5'd3, 1'b1, 32'h300, w);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (wb_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid got %b expected 1", wb_valid_o); end
      checks++; if (wb_data_o !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL bp_data got %h expected cafef00d", wb_data_o); end
      checks++; if (ex_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL bp_ex_ready got %b expected 0", ex_ready_o); end
      @(posedge clk); #1;
    end
    wb_ready_i = 1'b1;
    push_exp(32'h0BAD_BEEF, 1'b1, 5'd4, 1'b1, 32'h304, 1'b0);
    issue(8'h00, 32'h0BAD_BEEF, 32'h0, 32'h0, 5'd4, 1'b1, 32'h304, w);
    checks++; if (w !== 0) begin errors++; $display("[TB] FAIL bp_same_cycle_accept stalls got %0d expected 0", w); end
    wait_drain();
  endtask

  task automatic test_reset_mid_load();
    int w;
    gnt_delay = 0;
    hold_rvalid = 1'b1;
    mem_rdata = 32'h0000_0055;
    issue(I_LW, 32'h0, 32'h2000, 32'h0, 5'd20, 1'b1, 32'h500, w);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (dmem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL rstld_req got %b expected 0", dmem_req_o); end
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rstld_valid got %b expected 0", wb_valid_o); end
    checks++; if (ex_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL rstld_idle ex_ready got %b expected 1", ex_ready_o); end
    hold_rvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rstld_stray_rvalid wb_valid got %b expected 0", wb_valid_o); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_misalign();
    int w;
`ifdef LSU_MISALIGN_TRAP_EN
    logic req_seen;
    push_exp(32'h0000_3002, 1'b1, 5'd21, 1'b0, 32'h600, 1'b1);
    issue(I_LW, 32'h0, 32'h3002, 32'h0, 5'd21, 1'b1, 32'h600, w);
    req_seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (dmem_req_o) req_seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (req_seen !== 1'b0) begin errors++; $display("[TB] FAIL mis_no_req got %b expected 0", req_seen); end
    wait_drain();
`else
    gnt_delay = 0;
    mem_rdata = 32'hA5A5_5A5A;
    push_exp(32'h0000_A5A5, 1'b1, 5'd21, 1'b1, 32'h600, 1'b0);
    issue(I_LW, 32'h0, 32'h3002, 32'h0, 5'd21, 1'b1, 32'h600, w);
    @(negedge clk);
    checks++; if (dmem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL mis_req got %b expected 1", dmem_req_o); end
    checks++; if (dmem_addr_o !== 32'h3000) begin errors++; $display("[TB] FAIL mis_addr got %h expected 00003000", dmem_addr_o); end
    @(posedge clk); #1;
    wait_drain();

    push_exp(32'h0, 1'b0, 5'd22, 1'b0, 32'h604, 1'b0);
    issue(I_SH, 32'h0, 32'h1003, 32'h0000_1234, 5'd22, 1'b1, 32'h604, w);
    @(negedge clk);
    checks++; if (dmem_wstrb_o !== 4'b1000) begin errors++; $display("[TB] FAIL mis_sh_wstrb got %b expected 1000", dmem_wstrb_o); end
    @(posedge clk); #1;
    wait_drain();

    mem_rdata = 32'h8000_0000;
    push_exp(32'h0000_0080, 1'b1, 5'd23, 1'b1, 32'h608, 1'b0);
    issue(I_LH, 32'h0, 32'h2003, 32'h0, 5'd23, 1'b1, 32'h608, w);
    wait_drain();
`endif
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_loads();
    test_backpressure();
    test_reset_mid_load();
    test_misalign();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_leftover pending got %0d expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Memory-access stage of the pipelined core, directly downstream of the execute ALU.
- Consumes the execute results: ALU result, memory address, store data (rs2), load/store info, rd.
- Performs data-memory load/store over a req/gnt/rvalid handshake: byte-lane alignment, store strobes, load sign/zero extension.
- Hands a registered result to writeback over valid/ready. Non-memory instructions pass through with one-cycle latency.

Parameters:
- WIDTH, 32, data/address width; only 32 is supported.
- REG_WIDTH, 5, register index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_valid_i  in  1  execute result valid
- ex_ready_o  out  1  stage can accept
- load_store_info_i  in  8  one-hot: [7]lb [6]lh [5]lw [4]lbu [3]lhu [2]sb [1]sh [0]sw; all-zero = non-memory
- alu_result_i  in  WIDTH  ALU result, forwarded for non-memory ops
- mem_addr_i  in  WIDTH  byte address
- store_data_i  in  WIDTH  rs2 data
- rd_i  in  REG_WIDTH  destination register
- rd_wen_i  in  1  destination write enable
- pc_i  in  WIDTH  instruction PC
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  1 = store
- dmem_addr_o  out  WIDTH  word-aligned address ({addr[31:2],2'b00})
- dmem_wstrb_o  out  4  byte strobes
- dmem_wdata_o  out  WIDTH  lane-replicated store data
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  load data valid
- dmem_rdata_i  in  WIDTH  load word
- wb_valid_o  out  1  writeback valid
- wb_ready_i  in  1  writeback ready
- wb_rd_o  out  REG_WIDTH  destination register
- wb_wen_o  out  1  write enable
- wb_data_o  out  WIDTH  result data
- wb_pc_o  out  WIDTH  instruction PC
- misalign_o  out  1  misaligned access flag; present only with LSU_MISALIGN_TRAP_EN

Behaviour:
- Clock and reset: one clock clk; rst is synchronous, active-high.
- Reset: state IDLE. All outputs 0 (wb_*, dmem_*, misalign_o). ex_ready_o is 1 in the first cycle after reset.
- Reset mid-transaction abandons the access; dmem_req_o is low from the next cycle. Data memory shares rst.
- FSM states: IDLE, REQ, RESP, OUT.
- ex_ready_o = (state==IDLE) | (state==OUT & wb_ready_i).
- Accept (ex_valid_i & ex_ready_o): latch all inputs and the computed lanes/strobes.
  - Non-memory op -> OUT, wb_data = alu_result_i.
  - Load/store -> REQ.
- REQ: dmem_req_o=1, with addr/we/wstrb/wdata held stable until dmem_gnt_i.
  - gnt on a store -> OUT; wb_wen=0.
  - gnt on a load -> RESP.
- RESP: wait for dmem_rvalid_i; capture the extracted data -> OUT. rvalid outside RESP is ignored.
- OUT: wb_valid_o=1, all wb_* held until wb_ready_i.
  - Ready with a new ex_valid_i: accept back-to-back.
  - Ready without one: -> IDLE.
- Minimum latencies, accept at cycle N:
  - ALU op: wb_valid at N+1.
  - Store with immediate gnt: wb_valid at N+2.
  - Load with immediate gnt and rvalid next cycle: wb_valid at N+3.
- Lane offset off = addr[1:0].
  - Strobes: sb 4'b0001<<off; sh 4'b0011<<off; sw 4'b1111.
  - Store data replication: sb {4{d[7:0]}}; sh {2{d[15:0]}}; sw d.
- Load extraction: w = rdata >> (8*off).
  - lb sext(w[7:0]); lbu zext(w[7:0]); lh sext(w[15:0]); lhu zext(w[15:0]); lw w.
- Misalignment: halfword with off[0]=1, or word with off!=0.
  - Without the macro: the access is issued anyway. Strobe bits shifted past lane 3 are dropped; load bytes beyond lane 3 read as zero before extension.
- Multiple info bits set is a decoder error; the access takes the lowest-set-bit priority.

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined:
  - A misaligned access skips REQ and goes IDLE->OUT with wb_wen_o=0, wb_data_o=mem_addr, misalign_o=1. misalign_o is held with wb_valid_o.
  - No memory request is issued.
- Not defined: misalign_o is absent and misaligned accesses follow the truncation rules above.

Decomposition:
- Package lsu_pkg:
  - FSM state enum.
  - load_store_info bit-index constants (LS_LB..LS_SW).
  - Strobe base constants.
- Sub-module lsu_align (combinational): store strobe/data lane generation, load extraction/extension and misalign detect. It is instantiated once in lsu_mem_stage.

Test Plan:
- ALU pass-through: alu_result=0x1234_5678, info=0, wb_ready=1 -> wb_valid at N+1, wb_data=0x12345678; back-to-back ops at full rate.
- Store byte: sb addr=0x1003, rs2=0xAABBCCDD, gnt delayed 3 cycles -> req held 4 cycles, dmem_addr=0x1000, wstrb=4'b1000, wdata=0xDDDDDDDD; wb_wen=0.
- Load sign extension: lb addr=0x2002, rdata=0x0080_0000 -> wb_data=0xFFFFFF80; lbu -> 0x00000080; lhu addr=0x2002, rdata=0x8001_0000 -> 0x00008001.
- Backpressure: wb_ready=0 for 5 cycles in OUT -> wb_* stable, ex_ready_o=0; wb_ready rises with ex_valid=1 -> same-cycle accept.
- Reset mid-load: rst in RESP -> next cycle state IDLE, dmem_req_o=0, wb_valid_o=0; a later rvalid is ignored.
- Misalign lw addr=0x3002:
  - With LSU_MISALIGN_TRAP_EN: no dmem_req, misalign_o=1, wb_data=0x3002.
  - Without it: req issued at 0x3000 with wstrb unaffected (load).
